dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive denied debug-request cycles before a forced debug slot (legal 1..15).
REQ-002 Parameter: ADDR_W, 8, data-memory word-address width.
REQ-003 Port: clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: clear  input  1  reset, asynchronous, active-low.
REQ-005 Port: core_req  input  1  MEM-stage access request (MemRead or MemWrite).
REQ-006 Port: core_we  input  1  core write enable; 0 means read.
REQ-007 Port: core_addr  input  ADDR_W  core word address.
REQ-008 Port: core_wdata  input  32  core store data.
REQ-009 Port: core_stall  output  1  core access refused this cycle; pipeline holds.
REQ-010 Port: core_rvalid  output  1  core read data valid on core_rdata.
REQ-011 Port: core_rdata  output  32  core read data.
REQ-012 Port: dbg_req, dbg_we, dbg_addr, dbg_wdata  input  1/1/ADDR_W/32  debug/loader request, same meanings as the core port.
REQ-013 Port: dbg_gnt  output  1  debug access accepted this cycle.
REQ-014 Port: dbg_rvalid, dbg_rdata  output  1/32  debug read return.
REQ-015 Port: mem_addr, mem_din, mem_wren  output  ADDR_W/32/1  drive the single-port DataRAM.
REQ-016 Port: mem_dout  input  32  DataRAM registered read data, valid one cycle after the address is presented.

Function
REQ-017 Grant is combinational, decided in the same cycle as the request; mem_addr, mem_din and mem_wren shall come from the winner, or be all zero when there is no winner.
REQ-018 Normal state ARB: the core wins whenever core_req=1; the debug port wins only when core_req=0 and dbg_req=1.
REQ-019 core_stall = core_req & ~core_win; dbg_gnt = dbg_req & dbg_win.
REQ-020 Starvation counter (4 bits): increments on each cycle with dbg_req=1 and dbg_gnt=0; clears on dbg_gnt=1 or dbg_req=0; saturates at STARVE_LIMIT.
REQ-021 When the counter equals STARVE_LIMIT, the FSM shall move to state FORCE on the next edge.
REQ-022 State FORCE: the debug port wins regardless of core_req, core_stall=core_req, and the FSM returns to ARB on the next edge; exactly one forced slot per entry.
REQ-023 If dbg_req drops while in FORCE, there is no winner that cycle, the core is not stalled, and the FSM returns to ARB.
REQ-024 Read return: on a granted read (we=0), the owner shall be registered and <owner>_rvalid asserted exactly one cycle later; writes produce no rvalid.
REQ-025 core_rdata and dbg_rdata shall both equal mem_dout; only the rvalid signals distinguish the owner.
REQ-026 Back-to-back granted reads from alternating owners shall each return in order with a one-cycle latency and no bubble.

Reset
REQ-027 While clear=0: FSM=ARB, counter=0, core_rvalid=0, dbg_rvalid=0, and the registered owner is cleared; combinational outputs follow REQ-017 to REQ-019.
REQ-028 A reset asserted during an outstanding read shall suppress its rvalid; after release, the first granted read returns normally.

Configuration
REQ-029 Macro DMEM_ARB_FAIR_EN defined: starvation counter and FORCE state per REQ-020 to REQ-023.
REQ-030 Macro DMEM_ARB_FAIR_EN undefined: no counter or FORCE state; strict core priority, and the debug port can starve indefinitely.

Verification
REQ-031 Write then read: core writes 0xDEADBEEF to addr 0x10, then reads 0x10 -> core_rvalid=1 one cycle later, core_rdata=0xDEADBEEF, core_stall=0 throughout.
REQ-032 Contention: core_req and dbg_req both held, STARVE_LIMIT=4, FAIR_EN set -> dbg_gnt=0 for 4 cycles, dbg_gnt=1 and core_stall=1 on cycle 5, core wins on cycle 6.
REQ-033 Same as REQ-032 with FAIR_EN unset -> dbg_gnt stays 0 for 20 cycles and core_stall stays 0.
REQ-034 Alternating reads: dbg reads 0x03 (core idle), then core reads 0x04 on the next cycle -> dbg_rvalid followed by core_rvalid on consecutive cycles, each with its own memory word.
REQ-035 Reset mid-read: core read granted, clear pulled low before the next edge -> core_rvalid stays 0; FSM=ARB and counter=0 after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: core/debug arbiter in front of the single-port DataRAM.
// Define DMEM_ARB_FAIR_EN to add the anti-starvation forced debug slot.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [31:0]       core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              mem_wren,
  input  logic [31:0]       mem_dout
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("dmem_arbiter: STARVE_LIMIT must be 1..15");
  end

  logic core_win;
  logic dbg_win;
  logic in_force;

`ifdef DMEM_ARB_FAIR_EN
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  typedef enum logic {
    ARB,
    FORCE
  } state_t;

  state_t     state;
  logic [3:0] starve_cnt;
  logic [3:0] cnt_nxt;

  assign in_force = (state == FORCE);

  // Saturating count of consecutive refused debug cycles
  always_comb begin
    cnt_nxt = 4'd0;
    if (dbg_req && !dbg_gnt) begin
      if (starve_cnt >= LIM)
        cnt_nxt = LIM;
      else
        cnt_nxt = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state      <= ARB;
      starve_cnt <= 4'd0;
    end else begin
      starve_cnt <= cnt_nxt;
      unique case (state)
        ARB:     state <= (cnt_nxt == LIM) ? FORCE : ARB;
        FORCE:   state <= ARB;
        default: state <= ARB;
      endcase
    end
  end
`else
  assign in_force = 1'b0;
`endif

  always_comb begin
    core_win = 1'b0;
    dbg_win  = 1'b0;
    if (in_force)
      dbg_win = dbg_req;
    else if (core_req)
      core_win = 1'b1;
    else
      dbg_win = dbg_req;
  end

  // A forced slot left unused by the debug port does not hold the core
  assign core_stall = core_req & ~core_win
                    & ~(in_force & ~dbg_req);
  assign dbg_gnt    = dbg_req & dbg_win;

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_wren = 1'b0;
    unique case (1'b1)
      core_win: begin
        mem_addr = core_addr;
        mem_din  = core_wdata;
        mem_wren = core_we;
      end
      dbg_win: begin
        mem_addr = dbg_addr;
        mem_din  = dbg_wdata;
        mem_wren = dbg_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      core_rvalid <= 1'b0;
      dbg_rvalid  <= 1'b0;
    end else begin
      core_rvalid <= core_win & ~core_we;
      dbg_rvalid  <= dbg_win & ~dbg_we;
    end
  end

  assign core_rdata = mem_dout;
  assign dbg_rdata  = mem_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table, contention sequences and randomized
// traffic against a cycle-level reference model of dmem_arbiter.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;
  localparam int AW    = 8;
`ifdef DMEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          core_req = 0, core_we = 0;
  logic [AW-1:0] core_addr = '0;
  logic [31:0]   core_wdata = '0;
  logic          core_stall, core_rvalid;
  logic [31:0]   core_rdata;
  logic          dbg_req = 0, dbg_we = 0;
  logic [AW-1:0] dbg_addr = '0;
  logic [31:0]   dbg_wdata = '0;
  logic          dbg_gnt, dbg_rvalid;
  logic [31:0]   dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic          mem_wren;
  logic [31:0]   mem_dout = '0;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(AW)) dut (
    .clock(clock), .clear(clear),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wren(mem_wren), .mem_dout(mem_dout)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_word(int i);
    return {8'hA5, i[7:0], 8'h5A, ~i[7:0]};
  endfunction

  // Registered-read single-port RAM
  logic        ram_init = 1'b1;
  logic [31:0] ram [256];
  always @(posedge clock) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_wren) ram[mem_addr] <= mem_din;
      mem_dout <= ram[mem_addr];
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    bit          clr, drop, creq, cwe;
    logic [7:0]  caddr;
    logic [31:0] cwd;
    bit          dreq, dwe;
    logic [7:0]  daddr;
    logic [31:0] dwd;
  } in_t;

  typedef struct packed {
    bit          stall, gnt, crv, drv;
    logic [31:0] rd;
    logic [7:0]  maddr;
    bit          mwren;
  } out_t;

  typedef struct packed {
    in_t         i;
    bit          stall, gnt, crv, drv, chk_rd;
    logic [31:0] rd;
  } vec_t;

  // Reference model state
  int          starve;
  bit          forced;
  int          pend;
  logic [31:0] pend_data;
  logic [31:0] shadow [256];

  task automatic model_reset();
    starve = 0;
    forced = 0;
    pend   = 0;
  endtask

  task automatic run(input in_t v, output out_t o);
    int          win;
    bit          m_stall;
    logic [7:0]  e_addr;
    logic [31:0] e_din;
    bit          e_wren;
    core_req = v.creq; core_we = v.cwe;
    core_addr = v.caddr; core_wdata = v.cwd;
    dbg_req = v.dreq; dbg_we = v.dwe;
    dbg_addr = v.daddr; dbg_wdata = v.dwd;
    clear = v.clr;
    if (!v.clr) model_reset();
    #3;
    if (forced) begin
      win = v.dreq ? 2 : 0;
      m_stall = v.creq & v.dreq;
    end else begin
      win = v.creq ? 1 : (v.dreq ? 2 : 0);
      m_stall = 1'b0;
    end
    e_addr = 0; e_din = 0; e_wren = 0;
    if (win == 1) begin
      e_addr = v.caddr; e_din = v.cwd; e_wren = v.cwe;
    end else if (win == 2) begin
      e_addr = v.daddr; e_din = v.dwd; e_wren = v.dwe;
    end
    chk("core_stall", 32'(core_stall), 32'(m_stall));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(win == 2));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_din", mem_din, e_din);
    chk("mem_wren", 32'(mem_wren), 32'(e_wren));
    chk("core_rvalid", 32'(core_rvalid), 32'(pend == 1));
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(pend == 2));
    if (pend == 1) chk("core_rdata", core_rdata, pend_data);
    if (pend == 2) chk("dbg_rdata", dbg_rdata, pend_data);
    o.stall = core_stall; o.gnt = dbg_gnt;
    o.crv = core_rvalid; o.drv = dbg_rvalid;
    o.rd = core_rvalid ? core_rdata : dbg_rdata;
    o.maddr = mem_addr; o.mwren = mem_wren;
    if (v.drop) clear = 1'b0;
    @(posedge clock);
    #1;
    if (!clear) begin
      model_reset();
    end else begin
      pend = 0;
      if (win != 0) begin
        if (e_wren) shadow[e_addr] = e_din;
        else begin
          pend = win;
          pend_data = shadow[e_addr];
        end
      end
      if (win == 2 || !v.dreq) starve = 0;
      else if (starve < LIMIT) starve++;
      forced = !forced && FAIR && (starve >= LIMIT);
    end
  endtask

  function automatic vec_t mk(bit clr, bit drop,
      bit creq, bit cwe, logic [7:0] ca, logic [31:0] cw,
      bit dreq, bit dwe, logic [7:0] da, logic [31:0] dw,
      bit stall, bit gnt, bit crv, bit drv,
      bit chk_rd, logic [31:0] rd);
    vec_t t;
    t.i = '{clr: clr, drop: drop, creq: creq, cwe: cwe,
            caddr: ca, cwd: cw, dreq: dreq, dwe: dwe,
            daddr: da, dwd: dw};
    t.stall = stall; t.gnt = gnt; t.crv = crv; t.drv = drv;
    t.chk_rd = chk_rd; t.rd = rd;
    return t;
  endfunction

  vec_t tbl [14];
  out_t o;
  in_t  c;

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    model_reset();
    @(posedge clock);
    #1;
    ram_init = 1'b0;

    tbl[0]  = mk(0,0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0,0);
    tbl[1]  = mk(1,0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0,0);
    tbl[2]  = mk(1,0, 1,1,8'h10,32'hDEADBEEF, 0,0,8'h00,0,
                 0,0,0,0, 0,0);
    tbl[3]  = mk(1,0, 1,0,8'h10,0, 0,0,8'h00,0, 0,0,0,0, 0,0);
    tbl[4]  = mk(1,0, 0,0,8'h00,0, 0,0,8'h00,0,
                 0,0,1,0, 1,32'hDEADBEEF);
    tbl[5]  = mk(1,0, 0,0,8'h00,0, 1,0,8'h03,0, 0,1,0,0, 0,0);
    tbl[6]  = mk(1,0, 1,0,8'h04,0, 0,0,8'h00,0,
                 0,0,0,1, 1,init_word(3));
    tbl[7]  = mk(1,0, 0,0,8'h00,0, 0,0,8'h00,0,
                 0,0,1,0, 1,init_word(4));
    tbl[8]  = mk(1,0, 1,1,8'h20,32'h11111111,
                 1,1,8'h21,32'h22222222, 0,0,0,0, 0,0);
    tbl[9]  = mk(1,0, 0,0,8'h00,0, 1,0,8'h20,0, 0,1,0,0, 0,0);
    tbl[10] = mk(1,0, 0,0,8'h00,0, 0,0,8'h00,0,
                 0,0,0,1, 1,32'h11111111);
    tbl[11] = mk(1,1, 1,0,8'h21,0, 0,0,8'h00,0, 0,0,0,0, 0,0);
    tbl[12] = mk(0,0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0,0);
    tbl[13] = mk(1,0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0,0,0, 0,0);

    for (int k = 0; k < 14; k++) begin
      run(tbl[k].i, o);
      chk($sformatf("tbl%0d_stall", k), 32'(o.stall), 32'(tbl[k].stall));
      chk($sformatf("tbl%0d_gnt", k), 32'(o.gnt), 32'(tbl[k].gnt));
      chk($sformatf("tbl%0d_crv", k), 32'(o.crv), 32'(tbl[k].crv));
      chk($sformatf("tbl%0d_drv", k), 32'(o.drv), 32'(tbl[k].drv));
      if (tbl[k].chk_rd)
        chk($sformatf("tbl%0d_rdata", k), o.rd, tbl[k].rd);
    end

    // Sustained contention straight after the mid-read reset
    c = '{clr: 1, creq: 1, dreq: 1, caddr: 8'h05, daddr: 8'h06,
          default: 0};
    if (FAIR) begin
      for (int k = 1; k <= 6; k++) begin
        run(c, o);
        chk($sformatf("cont%0d_gnt", k), 32'(o.gnt), 32'(k == 5));
        chk($sformatf("cont%0d_stall", k), 32'(o.stall), 32'(k == 5));
      end
    end else begin
      for (int k = 1; k <= 20; k++) begin
        run(c, o);
        chk($sformatf("cont%0d_gnt", k), 32'(o.gnt), 0);
        chk($sformatf("cont%0d_stall", k), 32'(o.stall), 0);
      end
    end

    // Debug request withdrawn in what would be the forced slot
    c = '{clr: 1, default: 0};
    run(c, o);
    c = '{clr: 1, creq: 1, dreq: 1, caddr: 8'h05, daddr: 8'h06,
          default: 0};
    for (int k = 0; k < 4; k++) run(c, o);
    c.dreq = 0;
    run(c, o);
    chk("drop_stall", 32'(o.stall), 0);
    chk("drop_gnt", 32'(o.gnt), 0);
    chk("drop_maddr", 32'(o.maddr), FAIR ? 0 : 32'h05);
    c = '{clr: 1, default: 0};
    run(c, o);
    chk("drop_crv", 32'(o.crv), FAIR ? 0 : 1);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      c.clr   = ($urandom_range(0, 59) != 0);
      c.drop  = ($urandom_range(0, 79) == 0);
      c.creq  = ($urandom_range(0, 3) != 0);
      c.cwe   = ($urandom_range(0, 2) == 0);
      c.caddr = 8'($urandom_range(0, 15));
      c.cwd   = $urandom;
      c.dreq  = ($urandom_range(0, 2) != 0);
      c.dwe   = ($urandom_range(0, 2) == 0);
      c.daddr = 8'($urandom_range(0, 15));
      c.dwd   = $urandom;
      run(c, o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
